fp_csr_unit: RTL and testbench
==============================

# fp_csr_unit

Floating-point control/status register unit. It owns `frm` and `fflags` and supplies the rounding mode consumed by the FPU (`IN_fRoundMode`). It decodes the per-instruction `Flags` exception codes produced by FP execution units back into the 5-bit accrued `fflags` vector when those instructions commit. It also services serialized CSR accesses to `fflags`/`frm`/`fcsr` from the CSR path with a valid/ready handshake.

## Interface
- `NUM_COMMIT`, default 4: commit slots delivering flag events per cycle.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `IN_comValid` in `NUM_COMMIT`: slot i commits an FP instruction this cycle.
- `IN_comFlags` in `NUM_COMMIT` x `$bits(Flags)`: committed `Flags` code per slot.
- `IN_csrValid` in 1: CSR request valid.
- `OUT_csrReady` out 1: request accepted when valid and ready are both high.
- `IN_csrAddr` in 12: CSR address.
- `IN_csrOp` in 2: `FCSR_RW`, `FCSR_RS` or `FCSR_RC`.
- `IN_csrData` in 32: write/set/clear operand.
- `OUT_csrValid` out 1: response valid, single-cycle pulse.
- `OUT_csrData` out 32: old CSR value, zero-extended.
- `OUT_csrIllegal` out 1: response flags an illegal access.
- `OUT_fRoundMode` out 3: current `frm`.
- `OUT_frmInvalid` out 1: `frm >= 3'b101`.
- `OUT_fflags` out 5: current accrued flags.
- `OUT_fsDirty` out 1: FS-dirty pulse. See Configuration.

## Operation
- **Flag decode.** Each valid slot maps its `Flags` code to exactly one `fflags` bit:
  - `FLAGS_FP_NX` → bit 0
  - `FLAGS_FP_UF` → bit 1
  - `FLAGS_FP_OF` → bit 2
  - `FLAGS_FP_DZ` → bit 3
  - `FLAGS_FP_NV` → bit 4
  - Every other code, including `FLAGS_NONE` and `FLAGS_ILLEGAL_INSTR`, maps to 0.
- **Event stage S1.** The OR of all decoded slots is registered into S1, together with `s1Valid` = any slot valid with a nonzero decode.
  - The next cycle, `fflags <= fflags | s1Mask`.
- **CSR addresses.**
  - `0x001` `fflags`: bits [4:0].
  - `0x002` `frm`: bits [2:0].
  - `0x003` `fcsr`: `{frm, fflags}` in bits [7:0].
  - Any other address: the response has `OUT_csrIllegal=1`, data 0, no state change.
- **CSR ops.** `new = RW ? d : RS ? old|d : old&~d`, truncated to the field width. Upper bits of `d` are ignored.
- **Handshake.** `OUT_csrReady = !s1Valid`. A CSR access never overtakes pending accrued flags.
- **Same-cycle commit and CSR accept.** The CSR op is serializing, so commits in its accept cycle are younger.
  - They enter S1 normally.
  - They are applied after the CSR write, i.e. OR'd into the written value one cycle later.
- **Same-cycle S1 drain and CSR write.** This cannot occur: ready is low while S1 is valid.
- **Illegal `frm` values.** `frm` values 5–7 are stored as written. The only effect is `OUT_frmInvalid=1`; the FPU decides legality per dynamic-rounding instruction.

## Timing
- **Reset** (`rst=0` at a clock edge):
  - `frm=0`, `fflags=0`, `s1Valid=0`.
  - `OUT_csrValid=0`, `OUT_csrIllegal=0`, `OUT_csrData=0`, `OUT_fsDirty=0`.
  - `OUT_csrReady` reads 1 after the reset edge.
- **Reset mid-operation:** pending S1 flags and any in-flight response are discarded.
- **Flag latency:** a commit at cycle t is visible on `OUT_fflags` at t+2.
- **CSR latency:** accept at cycle t gives:
  - `OUT_csrValid`, `OUT_csrData` = pre-op value at t+1.
  - Register updated at t+1.
  - Back-to-back accepts are allowed every cycle while ready.
- **Rounding-mode latency:** `OUT_fRoundMode` changes at t+1 after a `frm`/`fcsr` write accepted at t.
- **Throughput:** there is no response backpressure; the consumer must take the response on the cycle it is valid.

## Configuration
- `FP_CSR_FS_DIRTY_EN` defined:
  - `OUT_fsDirty` pulses for one cycle whenever `frm` or `fflags` changes value, from either a CSR write or accrual.
  - The pulse is coincident with the cycle the new value first appears.
- Not defined: `OUT_fsDirty` is tied to 0 and the change-detect logic is absent.

## Structure
- Shared package contents:
  - `FCSR_FFLAGS`/`FCSR_FRM`/`FCSR_FCSR` address constants.
  - The `FcsrOp` enum (`FCSR_RW`=0, `FCSR_RS`=1, `FCSR_RC`=2; the value 3 behaves as illegal).
  - `FFLAG_NX..FFLAG_NV` bit-index constants.
- `Flags` stays where it already lives.
- One sub-module, `fp_flags_decode`: combinational `Flags` → 5-bit one-hot, instantiated once per commit slot.

## Test plan
- **Reset:** hold `rst=0` for 2 cycles → `OUT_fflags=0`, `OUT_fRoundMode=0`, `OUT_csrReady=1`, `OUT_csrValid=0`.
- **Flag accrual:** slot 0 `FLAGS_FP_NX`, slot 2 `FLAGS_FP_DZ`, slot 3 `FLAGS_NONE` at cycle t → `OUT_fflags=5'b01001` at t+2. A later `FLAGS_ILLEGAL_INSTR` leaves it unchanged.
- **`fcsr` write then read:** write `fcsr` RW `0x000000E5` → response data = old `{frm, fflags}`. Then `frm=3'b111` and `OUT_frmInvalid=1` next cycle. Then RC `frm` with `0x4` → data `0x7`, `frm=3`, `OUT_frmInvalid=0`.
- **Ordering:** `FLAGS_FP_OF` committed at t → `OUT_csrReady=0` at t+1. A CSR RS `fflags` `0x01` held valid is accepted at t+2 → data `0x04`, `fflags=0x05`.
- **Same-cycle commit and CSR:** CSR RW `fflags` `0x00` accepted at t alongside a `FLAGS_FP_NV` commit → response data = old value; `fflags=0x10` at t+2.
- **Illegal address:** CSR access to `0x004` → `OUT_csrIllegal=1`, data 0, no state change. With `FP_CSR_FS_DIRTY_EN`: `OUT_fsDirty` pulses only for value-changing updates; an RS with `0` does not pulse.

Source files
------------

// File: rtl/fp_csr_unit_pkg.sv
// fp_csr_unit_pkg: shared types and constants for the FP CSR unit.
//   Flags       - per-instruction exception/result code from the execution units
//   FCSR_*      - CSR addresses for fflags / frm / fcsr
//   FcsrOp      - CSR operation encoding (value 3 is treated as illegal)
//   FFLAG_*     - bit positions inside the 5-bit accrued fflags vector
//   fcsrApply() - RW/RS/RC combine of old value and operand
package fp_csr_unit_pkg;

    typedef enum logic [3:0] {
        FLAGS_NONE          = 4'd0,
        FLAGS_BRK           = 4'd1,
        FLAGS_TRAP          = 4'd2,
        FLAGS_EXCEPT        = 4'd3,
        FLAGS_ILLEGAL_INSTR = 4'd4,
        FLAGS_FP_NX         = 4'd5,
        FLAGS_FP_UF         = 4'd6,
        FLAGS_FP_OF         = 4'd7,
        FLAGS_FP_DZ         = 4'd8,
        FLAGS_FP_NV         = 4'd9,
        FLAGS_ORDERING      = 4'd10
    } Flags;

    localparam logic [11:0] FCSR_FFLAGS = 12'h001;
    localparam logic [11:0] FCSR_FRM    = 12'h002;
    localparam logic [11:0] FCSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        FCSR_RW = 2'd0,
        FCSR_RS = 2'd1,
        FCSR_RC = 2'd2
    } FcsrOp;

    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    // Only the low byte of any FP CSR is architected, so the combine is done
    // on 8 bits and callers truncate further to the target field.
    function automatic logic [7:0] fcsrApply(input logic [1:0] op,
                                             input logic [7:0] old,
                                             input logic [7:0] d);
        case (op)
            FCSR_RW: fcsrApply = d;
            FCSR_RS: fcsrApply = old | d;
            default: fcsrApply = old & ~d;
        endcase
    endfunction

endpackage

// File: rtl/fp_csr_unit_if.sv
// fp_csr_unit_if: CSR request/response channel into the FP CSR unit.
//   master - CSR path: drives IN_csr*, observes ready and the response
//   slave  - fp_csr_unit: drives OUT_csrReady and the single-cycle response
interface fp_csr_unit_if;
    logic        IN_csrValid;
    logic        OUT_csrReady;
    logic [11:0] IN_csrAddr;
    logic [1:0]  IN_csrOp;
    logic [31:0] IN_csrData;
    logic        OUT_csrValid;
    logic [31:0] OUT_csrData;
    logic        OUT_csrIllegal;

    modport master (
        output IN_csrValid, IN_csrAddr, IN_csrOp, IN_csrData,
        input  OUT_csrReady, OUT_csrValid, OUT_csrData, OUT_csrIllegal
    );

    modport slave (
        input  IN_csrValid, IN_csrAddr, IN_csrOp, IN_csrData,
        output OUT_csrReady, OUT_csrValid, OUT_csrData, OUT_csrIllegal
    );
endinterface

// File: rtl/fp_csr_unit_flags_decode.sv
// fp_flags_decode: combinational Flags code -> one-hot fflags bit.
//   IN_flags - committed Flags code for one slot
//   OUT_mask - 5-bit fflags contribution (zero for non-FP codes)
module fp_flags_decode
    import fp_csr_unit_pkg::*;
(
    input  Flags       IN_flags,
    output logic [4:0] OUT_mask
);
    always_comb begin
        OUT_mask = '0;
        case (IN_flags)
            FLAGS_FP_NX: OUT_mask[FFLAG_NX] = 1'b1;
            FLAGS_FP_UF: OUT_mask[FFLAG_UF] = 1'b1;
            FLAGS_FP_OF: OUT_mask[FFLAG_OF] = 1'b1;
            FLAGS_FP_DZ: OUT_mask[FFLAG_DZ] = 1'b1;
            FLAGS_FP_NV: OUT_mask[FFLAG_NV] = 1'b1;
            default:     OUT_mask = '0;
        endcase
    end
endmodule

// File: rtl/fp_csr_unit.sv
// fp_csr_unit: owns frm and accrued fflags.
//   clk, rst         - clock, synchronous active-low reset
//   IN_comValid/Flags- per-slot committed FP instruction and its Flags code
//   csr              - CSR request/response channel (fp_csr_unit_if.slave)
//   OUT_fRoundMode   - current frm; OUT_frmInvalid when frm is 5..7
//   OUT_fflags       - current accrued flags
//   OUT_fsDirty      - one-cycle pulse on any frm/fflags value change, only
//                      when FP_CSR_FS_DIRTY_EN is defined (else tied to 0)
module fp_csr_unit
    import fp_csr_unit_pkg::*;
#(
    parameter int NUM_COMMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_COMMIT-1:0] IN_comValid,
    input  Flags [NUM_COMMIT-1:0] IN_comFlags,
    fp_csr_unit_if.slave          csr,
    output logic [2:0]            OUT_fRoundMode,
    output logic                  OUT_frmInvalid,
    output logic [4:0]            OUT_fflags,
    output logic                  OUT_fsDirty
);
    logic [2:0] frm, frmNext;
    logic [4:0] fflags, fflagsNext;

    // Per-slot decode, masked by slot valid.
    logic [NUM_COMMIT-1:0][4:0] slotMask;
    for (genvar gi = 0; gi < NUM_COMMIT; gi++) begin : gSlot
        logic [4:0] dec;
        fp_flags_decode uDec (.IN_flags(IN_comFlags[gi]), .OUT_mask(dec));
        assign slotMask[gi] = IN_comValid[gi] ? dec : 5'b0;
    end

    logic [4:0] comMask;
    always_comb begin
        comMask = '0;
        for (int i = 0; i < NUM_COMMIT; i++) comMask |= slotMask[i];
    end

    // S1 holds flags of already-committed instructions; CSR accesses stall
    // behind it so a read never misses an older accrual.
    logic       s1Valid;
    logic [4:0] s1Mask;
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1Valid <= 1'b0;
            s1Mask  <= '0;
        end else begin
            s1Valid <= |comMask;
            s1Mask  <= comMask;
        end
    end

    assign csr.OUT_csrReady = !s1Valid;
    logic csrFire;
    assign csrFire = csr.IN_csrValid && !s1Valid;

    logic        hitFflags, hitFrm, hitFcsr, legal;
    logic [31:0] oldVal;
    logic [7:0]  newVal;
    always_comb begin
        hitFflags = csr.IN_csrAddr == FCSR_FFLAGS;
        hitFrm    = csr.IN_csrAddr == FCSR_FRM;
        hitFcsr   = csr.IN_csrAddr == FCSR_FCSR;
        legal     = (hitFflags || hitFrm || hitFcsr) && (csr.IN_csrOp != 2'd3);
        oldVal    = '0;
        if (hitFflags) oldVal = {27'b0, fflags};
        if (hitFrm)    oldVal = {29'b0, frm};
        if (hitFcsr)   oldVal = {24'b0, frm, fflags};
        newVal     = fcsrApply(csr.IN_csrOp, oldVal[7:0], csr.IN_csrData[7:0]);
        frmNext    = frm;
        fflagsNext = fflags;
        // A CSR write and an S1 drain never share a cycle (ready is low while
        // S1 is valid); same-cycle commits land in S1 and OR in afterwards.
        if (csrFire && legal) begin
            if (hitFflags) fflagsNext = newVal[4:0];
            if (hitFrm)    frmNext    = newVal[2:0];
            if (hitFcsr) begin
                frmNext    = newVal[7:5];
                fflagsNext = newVal[4:0];
            end
        end else if (s1Valid) begin
            fflagsNext = fflags | s1Mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frm                <= '0;
            fflags             <= '0;
            csr.OUT_csrValid   <= 1'b0;
            csr.OUT_csrIllegal <= 1'b0;
            csr.OUT_csrData    <= '0;
        end else begin
            frm                <= frmNext;
            fflags             <= fflagsNext;
            csr.OUT_csrValid   <= csrFire;
            csr.OUT_csrIllegal <= csrFire && !legal;
            if (csrFire) csr.OUT_csrData <= legal ? oldVal : 32'b0;
        end
    end

    assign OUT_fRoundMode = frm;
    assign OUT_frmInvalid = frm >= 3'b101;
    assign OUT_fflags     = fflags;

`ifdef FP_CSR_FS_DIRTY_EN
    // Registered alongside frm/fflags so the pulse lines up with the new value.
    always_ff @(posedge clk) begin
        if (!rst) OUT_fsDirty <= 1'b0;
        else      OUT_fsDirty <= (frmNext != frm) || (fflagsNext != fflags);
    end
`else
    assign OUT_fsDirty = 1'b0;
`endif

endmodule

// File: tb/tb_fp_csr_unit.sv
// tb_fp_csr_unit: directed self-checking bench for fp_csr_unit.
// Expected fsDirty values follow FP_CSR_FS_DIRTY_EN.
module tb_fp_csr_unit;
    import fp_csr_unit_pkg::*;

`ifdef FP_CSR_FS_DIRTY_EN
    localparam bit DIRTY = 1'b1;
`else
    localparam bit DIRTY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] comValid;
    Flags [3:0] comFlags;
    logic [2:0] roundMode;
    logic       frmInvalid;
    logic [4:0] fflags;
    logic       fsDirty;
    int         vecs = 0;
    int         errs = 0;

    fp_csr_unit_if csrIf ();

    fp_csr_unit #(.NUM_COMMIT(4)) dut (
        .clk(clk), .rst(rst),
        .IN_comValid(comValid), .IN_comFlags(comFlags),
        .csr(csrIf),
        .OUT_fRoundMode(roundMode), .OUT_frmInvalid(frmInvalid),
        .OUT_fflags(fflags), .OUT_fsDirty(fsDirty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csrReq(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csrIf.IN_csrValid = 1'b1;
        csrIf.IN_csrAddr  = a;
        csrIf.IN_csrOp    = op;
        csrIf.IN_csrData  = d;
    endtask

    task automatic idle();
        csrIf.IN_csrValid = 1'b0;
        comValid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        csrIf.IN_csrAddr = '0; csrIf.IN_csrOp = '0; csrIf.IN_csrData = '0;
        comFlags = {FLAGS_NONE, FLAGS_NONE, FLAGS_NONE, FLAGS_NONE};
        step(); step();
        vecs++; if (fflags !== 5'h0) begin errs++; $display("FAIL reset_fflags got=%h exp=00", fflags); end
        vecs++; if (roundMode !== 3'h0) begin errs++; $display("FAIL reset_frm got=%h exp=0", roundMode); end
        vecs++; if (csrIf.OUT_csrReady !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", csrIf.OUT_csrReady); end
        vecs++; if (csrIf.OUT_csrValid !== 1'b0) begin errs++; $display("FAIL reset_rspvalid got=%b exp=0", csrIf.OUT_csrValid); end
        vecs++; if (csrIf.OUT_csrIllegal !== 1'b0) begin errs++; $display("FAIL reset_illegal got=%b exp=0", csrIf.OUT_csrIllegal); end
        vecs++; if (csrIf.OUT_csrData !== 32'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", csrIf.OUT_csrData); end
        vecs++; if (fsDirty !== 1'b0) begin errs++; $display("FAIL reset_dirty got=%b exp=0", fsDirty); end
        rst = 1'b1;
    endtask

    task automatic test_accrual();
        // slot 1 carries OF but is not valid: must not contribute
        comValid = 4'b1101;
        comFlags = {FLAGS_NONE, FLAGS_FP_DZ, FLAGS_FP_OF, FLAGS_FP_NX};
        step();
        comValid = '0;
        vecs++; if (csrIf.OUT_csrReady !== 1'b0) begin errs++; $display("FAIL accr_ready_low got=%b exp=0", csrIf.OUT_csrReady); end
        vecs++; if (fflags !== 5'h00) begin errs++; $display("FAIL accr_t1 got=%h exp=00", fflags); end
        step();
        vecs++; if (fflags !== 5'b01001) begin errs++; $display("FAIL accr_t2 got=%b exp=01001", fflags); end
        vecs++; if (csrIf.OUT_csrReady !== 1'b1) begin errs++; $display("FAIL accr_ready_back got=%b exp=1", csrIf.OUT_csrReady); end
        vecs++; if (fsDirty !== DIRTY) begin errs++; $display("FAIL accr_dirty got=%b exp=%b", fsDirty, DIRTY); end
        comValid = 4'b0001;
        comFlags[0] = FLAGS_ILLEGAL_INSTR;
        step();
        comValid = '0;
        vecs++; if (csrIf.OUT_csrReady !== 1'b1) begin errs++; $display("FAIL accr_illinstr_ready got=%b exp=1", csrIf.OUT_csrReady); end
        step();
        vecs++; if (fflags !== 5'b01001) begin errs++; $display("FAIL accr_illinstr got=%b exp=01001", fflags); end
    endtask

    task automatic test_fcsr_rw();
        csrReq(FCSR_FCSR, FCSR_RW, 32'h000000E5);
        step();
        idle();
        vecs++; if (csrIf.OUT_csrValid !== 1'b1) begin errs++; $display("FAIL fcsr_rspvalid got=%b exp=1", csrIf.OUT_csrValid); end
        vecs++; if (csrIf.OUT_csrData !== 32'h09) begin errs++; $display("FAIL fcsr_old got=%h exp=09", csrIf.OUT_csrData); end
        vecs++; if (csrIf.OUT_csrIllegal !== 1'b0) begin errs++; $display("FAIL fcsr_illegal got=%b exp=0", csrIf.OUT_csrIllegal); end
        vecs++; if (roundMode !== 3'b111) begin errs++; $display("FAIL fcsr_frm got=%b exp=111", roundMode); end
        vecs++; if (frmInvalid !== 1'b1) begin errs++; $display("FAIL fcsr_frminv got=%b exp=1", frmInvalid); end
        vecs++; if (fflags !== 5'b00101) begin errs++; $display("FAIL fcsr_fflags got=%b exp=00101", fflags); end
        vecs++; if (fsDirty !== DIRTY) begin errs++; $display("FAIL fcsr_dirty got=%b exp=%b", fsDirty, DIRTY); end
        step();
        vecs++; if (csrIf.OUT_csrValid !== 1'b0) begin errs++; $display("FAIL fcsr_pulse got=%b exp=0", csrIf.OUT_csrValid); end
        vecs++; if (fsDirty !== 1'b0) begin errs++; $display("FAIL fcsr_dirty_clr got=%b exp=0", fsDirty); end
        csrReq(FCSR_FRM, FCSR_RC, 32'h4);
        step();
        idle();
        vecs++; if (csrIf.OUT_csrData !== 32'h7) begin errs++; $display("FAIL frm_rc_old got=%h exp=7", csrIf.OUT_csrData); end
        vecs++; if (roundMode !== 3'd3) begin errs++; $display("FAIL frm_rc_new got=%h exp=3", roundMode); end
        vecs++; if (frmInvalid !== 1'b0) begin errs++; $display("FAIL frm_rc_inv got=%b exp=0", frmInvalid); end
        csrReq(FCSR_FCSR, FCSR_RS, 32'h0);
        step();
        idle();
        vecs++; if (csrIf.OUT_csrData !== 32'h65) begin errs++; $display("FAIL fcsr_read got=%h exp=65", csrIf.OUT_csrData); end
        vecs++; if (fsDirty !== 1'b0) begin errs++; $display("FAIL fcsr_read_dirty got=%b exp=0", fsDirty); end
        step();
    endtask

    task automatic test_ordering();
        csrReq(FCSR_FFLAGS, FCSR_RW, 32'h0);
        step();
        idle();
        vecs++; if (fflags !== 5'h0) begin errs++; $display("FAIL ord_clear got=%h exp=00", fflags); end
        comValid = 4'b0010;
        comFlags[1] = FLAGS_FP_OF;
        step();
        comValid = '0;
        vecs++; if (csrIf.OUT_csrReady !== 1'b0) begin errs++; $display("FAIL ord_ready got=%b exp=0", csrIf.OUT_csrReady); end
        csrReq(FCSR_FFLAGS, FCSR_RS, 32'h01);
        step();
        vecs++; if (csrIf.OUT_csrValid !== 1'b0) begin errs++; $display("FAIL ord_stalled got=%b exp=0", csrIf.OUT_csrValid); end
        vecs++; if (fflags !== 5'h04) begin errs++; $display("FAIL ord_accrued got=%h exp=04", fflags); end
        step();
        idle();
        vecs++; if (csrIf.OUT_csrValid !== 1'b1) begin errs++; $display("FAIL ord_rspvalid got=%b exp=1", csrIf.OUT_csrValid); end
        vecs++; if (csrIf.OUT_csrData !== 32'h04) begin errs++; $display("FAIL ord_data got=%h exp=04", csrIf.OUT_csrData); end
        vecs++; if (fflags !== 5'h05) begin errs++; $display("FAIL ord_fflags got=%h exp=05", fflags); end
        step();
    endtask

    task automatic test_same_cycle();
        csrReq(FCSR_FFLAGS, FCSR_RW, 32'h0);
        comValid = 4'b1000;
        comFlags[3] = FLAGS_FP_NV;
        step();
        idle();
        vecs++; if (csrIf.OUT_csrData !== 32'h05) begin errs++; $display("FAIL same_old got=%h exp=05", csrIf.OUT_csrData); end
        vecs++; if (fflags !== 5'h00) begin errs++; $display("FAIL same_written got=%h exp=00", fflags); end
        vecs++; if (csrIf.OUT_csrReady !== 1'b0) begin errs++; $display("FAIL same_ready got=%b exp=0", csrIf.OUT_csrReady); end
        vecs++; if (fsDirty !== DIRTY) begin errs++; $display("FAIL same_dirty1 got=%b exp=%b", fsDirty, DIRTY); end
        step();
        vecs++; if (fflags !== 5'h10) begin errs++; $display("FAIL same_accrued got=%h exp=10", fflags); end
        vecs++; if (fsDirty !== DIRTY) begin errs++; $display("FAIL same_dirty2 got=%b exp=%b", fsDirty, DIRTY); end
    endtask

    task automatic test_illegal();
        csrReq(12'h004, FCSR_RW, 32'hFF);
        step();
        vecs++; if (csrIf.OUT_csrValid !== 1'b1) begin errs++; $display("FAIL ill_rspvalid got=%b exp=1", csrIf.OUT_csrValid); end
        vecs++; if (csrIf.OUT_csrIllegal !== 1'b1) begin errs++; $display("FAIL ill_flag got=%b exp=1", csrIf.OUT_csrIllegal); end
        vecs++; if (csrIf.OUT_csrData !== 32'h0) begin errs++; $display("FAIL ill_data got=%h exp=0", csrIf.OUT_csrData); end
        vecs++; if (fflags !== 5'h10) begin errs++; $display("FAIL ill_fflags got=%h exp=10", fflags); end
        vecs++; if (roundMode !== 3'd3) begin errs++; $display("FAIL ill_frm got=%h exp=3", roundMode); end
        vecs++; if (fsDirty !== 1'b0) begin errs++; $display("FAIL ill_dirty got=%b exp=0", fsDirty); end
        csrReq(FCSR_FFLAGS, 2'd3, 32'hFF);
        step();
        idle();
        vecs++; if (csrIf.OUT_csrIllegal !== 1'b1) begin errs++; $display("FAIL ill_op3 got=%b exp=1", csrIf.OUT_csrIllegal); end
        vecs++; if (fflags !== 5'h10) begin errs++; $display("FAIL ill_op3_fflags got=%h exp=10", fflags); end
        step();
        vecs++; if (csrIf.OUT_csrIllegal !== 1'b0) begin errs++; $display("FAIL ill_pulse got=%b exp=0", csrIf.OUT_csrIllegal); end
        csrReq(FCSR_FFLAGS, FCSR_RS, 32'h0);
        step();
        vecs++; if (csrIf.OUT_csrData !== 32'h10) begin errs++; $display("FAIL rs0_data got=%h exp=10", csrIf.OUT_csrData); end
        vecs++; if (fsDirty !== 1'b0) begin errs++; $display("FAIL rs0_dirty got=%b exp=0", fsDirty); end
        csrReq(FCSR_FFLAGS, FCSR_RS, 32'h1);
        step();
        idle();
        vecs++; if (fflags !== 5'h11) begin errs++; $display("FAIL rs1_fflags got=%h exp=11", fflags); end
        vecs++; if (fsDirty !== DIRTY) begin errs++; $display("FAIL rs1_dirty got=%b exp=%b", fsDirty, DIRTY); end
        step();
    endtask

    task automatic test_back_to_back();
        csrReq(FCSR_FRM, FCSR_RW, 32'h1);
        step();
        vecs++; if (csrIf.OUT_csrData !== 32'h3) begin errs++; $display("FAIL b2b_0_data got=%h exp=3", csrIf.OUT_csrData); end
        vecs++; if (roundMode !== 3'd1) begin errs++; $display("FAIL b2b_0_frm got=%h exp=1", roundMode); end
        csrReq(FCSR_FRM, FCSR_RW, 32'h2);
        step();
        vecs++; if (csrIf.OUT_csrValid !== 1'b1) begin errs++; $display("FAIL b2b_1_valid got=%b exp=1", csrIf.OUT_csrValid); end
        vecs++; if (csrIf.OUT_csrData !== 32'h1) begin errs++; $display("FAIL b2b_1_data got=%h exp=1", csrIf.OUT_csrData); end
        vecs++; if (roundMode !== 3'd2) begin errs++; $display("FAIL b2b_1_frm got=%h exp=2", roundMode); end
        csrReq(FCSR_FRM, FCSR_RS, 32'h4);
        step();
        idle();
        vecs++; if (csrIf.OUT_csrData !== 32'h2) begin errs++; $display("FAIL b2b_2_data got=%h exp=2", csrIf.OUT_csrData); end
        vecs++; if (roundMode !== 3'd6) begin errs++; $display("FAIL b2b_2_frm got=%h exp=6", roundMode); end
        vecs++; if (frmInvalid !== 1'b1) begin errs++; $display("FAIL b2b_2_inv got=%b exp=1", frmInvalid); end
        step();
        vecs++; if (csrIf.OUT_csrValid !== 1'b0) begin errs++; $display("FAIL b2b_end got=%b exp=0", csrIf.OUT_csrValid); end
    endtask

    task automatic test_reset_mid();
        csrReq(FCSR_FRM, FCSR_RW, 32'h5);
        comValid = 4'b0001;
        comFlags[0] = FLAGS_FP_NX;
        step();
        idle();
        vecs++; if (roundMode !== 3'd5) begin errs++; $display("FAIL rmid_frm got=%h exp=5", roundMode); end
        rst = 1'b0;
        step();
        vecs++; if (csrIf.OUT_csrValid !== 1'b0) begin errs++; $display("FAIL rmid_rspvalid got=%b exp=0", csrIf.OUT_csrValid); end
        vecs++; if (roundMode !== 3'd0) begin errs++; $display("FAIL rmid_frm0 got=%h exp=0", roundMode); end
        vecs++; if (fflags !== 5'h0) begin errs++; $display("FAIL rmid_fflags got=%h exp=00", fflags); end
        vecs++; if (csrIf.OUT_csrReady !== 1'b1) begin errs++; $display("FAIL rmid_ready got=%b exp=1", csrIf.OUT_csrReady); end
        rst = 1'b1;
        step();
        vecs++; if (fflags !== 5'h0) begin errs++; $display("FAIL rmid_s1_discard got=%h exp=00", fflags); end
    endtask

    initial begin
        test_reset();
        test_accrual();
        test_fcsr_rw();
        test_ordering();
        test_same_cycle();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
